// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: walks a raster timing grid, fetches stored pixels with
// integer replication, and emits pix/de/hsync/vsync aligned to 1-clk read latency.
module framebuffer_scanout #(
  parameter int FRAME_WIDTH    = 4,
  parameter int FRAME_HEIGHT   = 3,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int H_FRONT        = 2,
  parameter int H_SYNC         = 2,
  parameter int H_BACK         = 2,
  parameter int V_FRONT        = 1,
  parameter int V_SYNC         = 1,
  parameter int V_BACK         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fb_rst_busy,
  output logic                  en_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic [DATA_WIDTH-1:0] pix,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_ACT = FRAME_WIDTH * SCALING_FACTOR;
  localparam int H_TOT = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_ACT = FRAME_HEIGHT * SCALING_FACTOR;
  localparam int V_TOT = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int RW    = $clog2(SCALING_FACTOR + 1);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACT + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACT + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [RW-1:0] REP_LAST = RW'(SCALING_FACTOR - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(FRAME_WIDTH);

  if (FRAME_WIDTH * FRAME_HEIGHT > (1 << ADDR_WIDTH)) begin : g_fb_too_big
    $error("framebuffer_scanout: FRAME_WIDTH*FRAME_HEIGHT exceeds address space");
  end
  if (SCALING_FACTOR < 1) begin : g_bad_scale
    $error("framebuffer_scanout: SCALING_FACTOR must be >= 1");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_nxt;

  logic [HW-1:0]         hcnt;
  logic [VW-1:0]         vcnt;
  logic [RW-1:0]         hrep;
  logic [RW-1:0]         vrep;
  logic [ADDR_WIDTH-1:0] hpix;
  logic [ADDR_WIDTH-1:0] line_base;

  logic run, h_act, v_act, h_wrap, v_wrap;
  logic act_s0, hs_s0, vs_s0, fs_s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fb_rst_busy) state_nxt = RUN;
      RUN:     if (fb_rst_busy)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign run    = (state == RUN);
  assign h_act  = (hcnt < H_ACT_C);
  assign v_act  = (vcnt < V_ACT_C);
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // Counters sit at zero whenever the next cycle is not a continuing RUN cycle,
  // so every entry into RUN starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      hrep      <= '0;
      vrep      <= '0;
      hpix      <= '0;
      line_base <= '0;
    end else if (!run || fb_rst_busy) begin
      hcnt      <= '0;
      vcnt      <= '0;
      hrep      <= '0;
      vrep      <= '0;
      hpix      <= '0;
      line_base <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      hrep <= '0;
      hpix <= '0;
      if (v_wrap) begin
        vcnt      <= '0;
        vrep      <= '0;
        line_base <= '0;
      end else begin
        vcnt <= vcnt + VW'(1);
        if (v_act) begin
          if (vrep == REP_LAST) begin
            vrep      <= '0;
            line_base <= line_base + LINE_STEP;
          end else begin
            vrep <= vrep + RW'(1);
          end
        end
      end
    end else begin
      hcnt <= hcnt + HW'(1);
      if (h_act) begin
        if (hrep == REP_LAST) begin
          hrep <= '0;
          hpix <= hpix + ADDR_WIDTH'(1);
        end else begin
          hrep <= hrep + RW'(1);
        end
      end
    end
  end

  assign act_s0  = run && h_act && v_act;
  assign hs_s0   = run && (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_s0   = run && (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign fs_s0   = run && (hcnt == '0) && (vcnt == '0);
  assign en_rd   = act_s0;
  assign addr_rd = act_s0 ? (line_base + hpix) : '0;

  // One register stage so the timing strobes line up with the memory read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= act_s0;
      hsync       <= hs_s0;
      vsync       <= vs_s0;
      frame_start <= fs_s0;
    end
  end

  assign pix = de ? dout : '0;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout: default geometry plus a 2x scaled
// instance, each fed by a 1-clk-latency memory holding data == address.
module tb_framebuffer_scanout;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy = 1'b1;
  logic       busy2 = 1'b1;

  logic       en_rd, de, hsync, vsync, frame_start;
  logic [3:0] addr_rd;
  logic [7:0] dout = 8'h0;
  logic [7:0] pix;

  logic       en_rd2, de2, hsync2, vsync2, frame_start2;
  logic [3:0] addr_rd2;
  logic [7:0] dout2 = 8'h0;
  logic [7:0] pix2;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  framebuffer_scanout dut (
    .clk(clk), .rst(rst), .fb_rst_busy(busy), .en_rd(en_rd), .addr_rd(addr_rd),
    .dout(dout), .pix(pix), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  framebuffer_scanout #(.SCALING_FACTOR(2)) dut2 (
    .clk(clk), .rst(rst), .fb_rst_busy(busy2), .en_rd(en_rd2), .addr_rd(addr_rd2),
    .dout(dout2), .pix(pix2), .de(de2), .hsync(hsync2), .vsync(vsync2),
    .frame_start(frame_start2)
  );

  always @(posedge clk) begin
    if (en_rd)  dout  <= mem[addr_rd];
    if (en_rd2) dout2 <= mem[addr_rd2];
  end

  function automatic bit m_act(int h, int v, int sf);
    return (h < 4 * sf) && (v < 3 * sf);
  endfunction

  function automatic int m_addr(int h, int v, int sf);
    return m_act(h, v, sf) ? ((v / sf) * 4 + h / sf) : 0;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++; if (de !== 1'b0)          begin n_fail++; $display("FAIL rst_async_de got %b exp 0", de); end
    n_checks++; if (pix !== 8'h0)         begin n_fail++; $display("FAIL rst_async_pix got %h exp 00", pix); end
    n_checks++; if (hsync !== 1'b0)       begin n_fail++; $display("FAIL rst_async_hsync got %b exp 0", hsync); end
    n_checks++; if (vsync !== 1'b0)       begin n_fail++; $display("FAIL rst_async_vsync got %b exp 0", vsync); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_fs got %b exp 0", frame_start); end
    n_checks++; if (en_rd !== 1'b0)       begin n_fail++; $display("FAIL rst_async_en_rd got %b exp 0", en_rd); end
    n_checks++; if (addr_rd !== 4'h0)     begin n_fail++; $display("FAIL rst_async_addr got %h exp 0", addr_rd); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (en_rd !== 1'b0) begin n_fail++; $display("FAIL idle_en_rd c=%0d got %b exp 0", c, en_rd); end
      n_checks++; if (de !== 1'b0)    begin n_fail++; $display("FAIL idle_de c=%0d got %b exp 0", c, de); end
      n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL idle_vsync c=%0d got %b exp 0", c, vsync); end
    end
  endtask

  task automatic test_frame();
    int h = 0, v = 0, p_addr = 0;
    bit p_act = 0, p_hs = 0, p_vs = 0, p_fs = 0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    int de_first = -1, line1_first = -1, hs_first = -1, fs_first = -1, fs_second = -1;
    busy = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      n_checks++; if (en_rd !== m_act(h, v, 1)) begin n_fail++; $display("FAIL frame_en_rd c=%0d got %b exp %b", c, en_rd, m_act(h, v, 1)); end
      n_checks++; if (addr_rd !== 4'(m_addr(h, v, 1))) begin n_fail++; $display("FAIL frame_addr c=%0d got %0d exp %0d", c, addr_rd, m_addr(h, v, 1)); end
      n_checks++; if (de !== p_act) begin n_fail++; $display("FAIL frame_de c=%0d got %b exp %b", c, de, p_act); end
      n_checks++; if (pix !== (p_act ? 8'(p_addr) : 8'h0)) begin n_fail++; $display("FAIL frame_pix c=%0d got %0d exp %0d", c, pix, p_act ? p_addr : 0); end
      n_checks++; if (hsync !== p_hs) begin n_fail++; $display("FAIL frame_hsync c=%0d got %b exp %b", c, hsync, p_hs); end
      n_checks++; if (vsync !== p_vs) begin n_fail++; $display("FAIL frame_vsync c=%0d got %b exp %b", c, vsync, p_vs); end
      n_checks++; if (frame_start !== p_fs) begin n_fail++; $display("FAIL frame_fs c=%0d got %b exp %b", c, frame_start, p_fs); end
      if (de) begin
        n_checks++; if (pix !== 8'(de_cnt % 12)) begin n_fail++; $display("FAIL frame_pix_order n=%0d got %0d exp %0d", de_cnt, pix, de_cnt % 12); end
        if (de_first < 0) de_first = c;
        if (pix == 8'd4 && line1_first < 0) line1_first = c;
        de_cnt++;
      end
      if (hsync) begin if (hs_first < 0) hs_first = c; hs_cnt++; end
      if (vsync) vs_cnt++;
      if (frame_start) begin
        if (fs_cnt == 0) fs_first = c; else fs_second = c;
        fs_cnt++;
      end
      p_act  = m_act(h, v, 1);
      p_addr = m_addr(h, v, 1);
      p_hs   = (h >= 6) && (h < 8);
      p_vs   = (v == 4);
      p_fs   = (h == 0) && (v == 0);
      h++;
      if (h == 10) begin h = 0; v = (v + 1) % 6; end
    end
    n_checks++; if (de_cnt != 24) begin n_fail++; $display("FAIL frame_de_count got %0d exp 24", de_cnt); end
    n_checks++; if (hs_cnt != 24) begin n_fail++; $display("FAIL frame_hs_count got %0d exp 24", hs_cnt); end
    n_checks++; if (vs_cnt != 20) begin n_fail++; $display("FAIL frame_vs_count got %0d exp 20", vs_cnt); end
    n_checks++; if (fs_cnt != 2)  begin n_fail++; $display("FAIL frame_fs_count got %0d exp 2", fs_cnt); end
    n_checks++; if (de_first != 1) begin n_fail++; $display("FAIL frame_first_de got %0d exp 1", de_first); end
    n_checks++; if (line1_first - de_first != 10) begin n_fail++; $display("FAIL frame_line_period got %0d exp 10", line1_first - de_first); end
    n_checks++; if (hs_first - de_first != 6) begin n_fail++; $display("FAIL frame_hs_offset got %0d exp 6", hs_first - de_first); end
    n_checks++; if (fs_second - fs_first != 60) begin n_fail++; $display("FAIL frame_period got %0d exp 60", fs_second - fs_first); end
  endtask

  task automatic test_scale2();
    int h = 0, v = 0, p_addr = 0, de_cnt = 0, second_line = -1;
    bit p_act = 0;
    busy2 = 1'b0;
    for (int c = 0; c < 126; c++) begin
      @(negedge clk);
      n_checks++; if (en_rd2 !== m_act(h, v, 2)) begin n_fail++; $display("FAIL scale_en_rd c=%0d got %b exp %b", c, en_rd2, m_act(h, v, 2)); end
      n_checks++; if (addr_rd2 !== 4'(m_addr(h, v, 2))) begin n_fail++; $display("FAIL scale_addr c=%0d got %0d exp %0d", c, addr_rd2, m_addr(h, v, 2)); end
      n_checks++; if (de2 !== p_act) begin n_fail++; $display("FAIL scale_de c=%0d got %b exp %b", c, de2, p_act); end
      if (de2) begin
        n_checks++;
        if (pix2 !== 8'(((de_cnt / 8) / 2) * 4 + (de_cnt % 8) / 2)) begin
          n_fail++; $display("FAIL scale_pix_order n=%0d got %0d exp %0d", de_cnt, pix2, ((de_cnt / 8) / 2) * 4 + (de_cnt % 8) / 2);
        end
        if (de_cnt == 8) second_line = c;
        de_cnt++;
      end
      p_act  = m_act(h, v, 2);
      p_addr = m_addr(h, v, 2);
      h++;
      if (h == 14) begin h = 0; v = (v + 1) % 9; end
    end
    n_checks++; if (de_cnt != 48) begin n_fail++; $display("FAIL scale_de_count got %0d exp 48", de_cnt); end
    n_checks++; if (second_line != 15) begin n_fail++; $display("FAIL scale_line_period got %0d exp 15", second_line); end
  endtask

  task automatic test_abort();
    int de_cnt = 0, fs_cnt = 0;
    busy = 1'b1;
    repeat (2) @(negedge clk);
    busy = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks++; if (en_rd !== m_act(c % 10, c / 10, 1)) begin n_fail++; $display("FAIL abort_pre_en_rd c=%0d got %b", c, en_rd); end
      n_checks++; if (addr_rd !== 4'(m_addr(c % 10, c / 10, 1))) begin n_fail++; $display("FAIL abort_pre_addr c=%0d got %0d exp %0d", c, addr_rd, m_addr(c % 10, c / 10, 1)); end
    end
    busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++; if (en_rd !== 1'b0) begin n_fail++; $display("FAIL abort_en_rd k=%0d got %b exp 0", k, en_rd); end
      n_checks++; if (addr_rd !== 4'h0) begin n_fail++; $display("FAIL abort_addr k=%0d got %0d exp 0", k, addr_rd); end
      n_checks++; if (de !== (k == 1)) begin n_fail++; $display("FAIL abort_de k=%0d got %b exp %b", k, de, k == 1); end
      n_checks++; if (pix !== ((k == 1) ? 8'd7 : 8'd0)) begin n_fail++; $display("FAIL abort_pix k=%0d got %0d", k, pix); end
    end
    busy = 1'b0;
    @(negedge clk);
    n_checks++; if (en_rd !== 1'b1 || addr_rd !== 4'h0) begin n_fail++; $display("FAIL abort_restart_rd got en=%b addr=%0d exp en=1 addr=0", en_rd, addr_rd); end
    n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL abort_restart_de0 got %b exp 0", de); end
    @(negedge clk);
    n_checks++; if (de !== 1'b1 || pix !== 8'd0 || frame_start !== 1'b1) begin
      n_fail++; $display("FAIL abort_first_pix got de=%b pix=%0d fs=%b exp de=1 pix=0 fs=1", de, pix, frame_start);
    end
    de_cnt = 1;
    for (int c = 2; c < 60; c++) begin
      @(negedge clk);
      if (de) begin
        n_checks++; if (pix !== 8'(de_cnt)) begin n_fail++; $display("FAIL abort_pix_order n=%0d got %0d exp %0d", de_cnt, pix, de_cnt); end
        de_cnt++;
      end
      if (frame_start) fs_cnt++;
    end
    n_checks++; if (de_cnt != 12) begin n_fail++; $display("FAIL abort_de_count got %0d exp 12", de_cnt); end
    n_checks++; if (fs_cnt != 0)  begin n_fail++; $display("FAIL abort_extra_fs got %0d exp 0", fs_cnt); end
  endtask

  task automatic test_async_reset();
    int de_cnt = 0, fs_cnt = 0;
    busy = 1'b1;
    repeat (2) @(negedge clk);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (de !== 1'b1 || pix !== 8'd1 || en_rd !== 1'b1 || addr_rd !== 4'd2) begin
      n_fail++; $display("FAIL arst_pre got de=%b pix=%0d en=%b addr=%0d exp 1/1/1/2", de, pix, en_rd, addr_rd);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (de !== 1'b0)          begin n_fail++; $display("FAIL arst_de got %b exp 0", de); end
    n_checks++; if (pix !== 8'h0)         begin n_fail++; $display("FAIL arst_pix got %0d exp 0", pix); end
    n_checks++; if (en_rd !== 1'b0)       begin n_fail++; $display("FAIL arst_en_rd got %b exp 0", en_rd); end
    n_checks++; if (addr_rd !== 4'h0)     begin n_fail++; $display("FAIL arst_addr got %0d exp 0", addr_rd); end
    n_checks++; if (hsync !== 1'b0 || vsync !== 1'b0 || frame_start !== 1'b0) begin
      n_fail++; $display("FAIL arst_sync got hs=%b vs=%b fs=%b exp 0", hsync, vsync, frame_start);
    end
    @(negedge clk);
    n_checks++; if (de !== 1'b0 || en_rd !== 1'b0) begin n_fail++; $display("FAIL arst_hold got de=%b en=%b exp 0", de, en_rd); end
    rst = 1'b0;
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (en_rd !== 1'b1 || addr_rd !== 4'h0 || de !== 1'b0) begin
          n_fail++; $display("FAIL arst_restart got en=%b addr=%0d de=%b exp 1/0/0", en_rd, addr_rd, de);
        end
      end
      if (de) begin
        n_checks++; if (pix !== 8'(de_cnt % 12)) begin n_fail++; $display("FAIL arst_pix_order n=%0d got %0d exp %0d", de_cnt, pix, de_cnt % 12); end
        de_cnt++;
      end
      if (frame_start) begin
        n_checks++; if (c != 1 && c != 61) begin n_fail++; $display("FAIL arst_fs_pos got %0d exp 1", c); end
        fs_cnt++;
      end
    end
    n_checks++; if (de_cnt != 12) begin n_fail++; $display("FAIL arst_de_count got %0d exp 12", de_cnt); end
    n_checks++; if (fs_cnt != 1)  begin n_fail++; $display("FAIL arst_fs_count got %0d exp 1", fs_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    test_reset();
    test_frame();
    test_scale2();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 The block SHALL have these parameters, one per line:
- FRAME_WIDTH, 4: stored pixels per line.
- FRAME_HEIGHT, 3: stored lines.
- SCALING_FACTOR, 1: replication of each stored pixel/line; must be >=1.
- ADDR_WIDTH, 4: framebuffer address width.
- DATA_WIDTH, 8: pixel width.
- H_FRONT / H_SYNC / H_BACK, 2 / 2 / 2: horizontal blanking widths, in clocks.
- V_FRONT / V_SYNC / V_BACK, 1 / 1 / 1: vertical blanking heights, in lines.
REQ-002 The block SHALL have these ports, one per line:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- fb_rst_busy, in, 1: framebuffer clear in progress; scanout held off while high.
- en_rd, out, 1: framebuffer read enable.
- addr_rd, out, ADDR_WIDTH: framebuffer read address.
- dout, in, DATA_WIDTH: framebuffer read data, valid exactly 1 clk after en_rd.
- pix, out, DATA_WIDTH: output pixel.
- de, out, 1: pix valid (active video).
- hsync, out, 1: active-high horizontal sync.
- vsync, out, 1: active-high vertical sync.
- frame_start, out, 1: one-clock pulse aligned with the first de of a frame.

Function
REQ-003 Derived sizes SHALL be H_ACT=FRAME_WIDTH*SCALING_FACTOR, H_TOT=H_ACT+H_FRONT+H_SYNC+H_BACK, V_ACT=FRAME_HEIGHT*SCALING_FACTOR, V_TOT=V_ACT+V_FRONT+V_SYNC+V_BACK.
REQ-004 FSM states SHALL be IDLE and RUN; IDLE->RUN when fb_rst_busy==0; RUN->IDLE when fb_rst_busy==1 (frame abort, any position).
REQ-005 In IDLE, counters SHALL be 0, en_rd=0, addr_rd=0, and pix/de/hsync/vsync/frame_start SHALL all be 0 one clk later.
REQ-006 In RUN, hcnt SHALL count 0..H_TOT-1 and wrap to 0; vcnt SHALL increment on hcnt wrap, counting 0..V_TOT-1 and wrapping to 0.
REQ-007 Stage-0 active SHALL be hcnt<H_ACT && vcnt<V_ACT; en_rd SHALL equal stage-0 active.
REQ-008 addr_rd SHALL equal (vcnt/SCALING_FACTOR)*FRAME_WIDTH + hcnt/SCALING_FACTOR, computed with replication sub-counters and a line-base register (no dividers or multipliers), and SHALL be 0 outside active.
REQ-009 Stage-0 hsync SHALL be high for H_ACT+H_FRONT <= hcnt < H_ACT+H_FRONT+H_SYNC; stage-0 vsync SHALL be high for V_ACT+V_FRONT <= vcnt < V_ACT+V_FRONT+V_SYNC, for whole lines.
REQ-010 de, hsync, vsync and frame_start SHALL be registered copies of their stage-0 values (1-clk latency) so they align with dout.
REQ-011 pix SHALL equal dout when de=1 and 0 otherwise.
REQ-012 frame_start SHALL be high for the single clk where de=1 and the pixel comes from hcnt=0, vcnt=0.
REQ-013 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; FRAME_WIDTH*FRAME_HEIGHT must not exceed 2^ADDR_WIDTH (elaboration-time check).
REQ-014 When fb_rst_busy rises mid-frame, the next edge SHALL enter IDLE and the following clk SHALL show de=0; on release, scanout SHALL restart at hcnt=0, vcnt=0 with no partial frame resumed.

Reset
REQ-015 While rst=1, the FSM SHALL be in IDLE, counters and pipeline registers SHALL be 0, and all outputs SHALL be 0 immediately, without waiting for a clock edge.
REQ-016 After rst deasserts, RUN SHALL be entered on the first edge where fb_rst_busy==0.

Verification
REQ-017 Defaults, fb preloaded with addr==data, fb_rst_busy=0 after reset -> per frame: 12 de pulses with pix 0..11 in order; 4 de per line; line period 10 clks; frame period 60 clks.
REQ-018 Defaults -> hsync high for 2 clks starting 6 clks after the line's first stage-0 active clk (shifted +1 at outputs); vsync high for exactly 10 clks per frame; frame_start once per frame, coincident with pix=0.
REQ-019 SCALING_FACTOR=2 -> line pix sequence 0,0,1,1,2,2,3,3, repeated on 2 consecutive lines; 48 de pulses per frame; H_TOT=14.
REQ-020 fb_rst_busy asserted 3 clks into line 1 for 5 clks -> en_rd=0 and, 1 clk later, de=0 throughout; after release the first de carries pix=0 with frame_start=1.
REQ-021 rst pulsed asynchronously mid-line (between edges) -> all outputs 0 before the next edge; normal frame restarts from pix 0 after release.
REQ-022 Check en_rd/addr_rd each clk against the REQ-008 formula, with dout driven from a 1-clk-latency memory model.
